// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  // Tag kept per outstanding memory request: where it was fetched from and in which epoch
  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
  } fetch_tag_t;

  // Entry handed to decode
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;

  // Sequential successor of a fetch address; wraps at 2^32
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, full/empty/count; DEPTH must be a power of two
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  // A pop frees the slot in the same cycle, so a push at full is accepted alongside it
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  // Empty reads as zero so downstream data is clean while nothing is valid
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything including a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; no reset needed because reads are masked while empty
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; define FETCH_MISALIGN_TRAP_EN for misaligned-redirect trap
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);
  localparam int            TAG_W     = $bits(fetch_tag_t);
  localparam int            ENTRY_W   = $bits(fetch_entry_t);

  logic [31:0]   r_pc;
  logic          r_epoch;

  logic          w_req_fire;
  logic          w_halted;
  logic [31:0]   w_redirect_target;
  logic [CW:0]   w_inflight;
  logic          w_rsp_pop;
  logic          w_rsp_keep;

  fetch_tag_t    w_tag_in;
  fetch_tag_t    w_tag_head;
  logic          w_tag_full_unused;
  logic          w_tag_empty;
  logic [CW-1:0] w_outstanding;

  fetch_entry_t  w_entry_in;
  fetch_entry_t  w_entry_head;
  logic          w_instr_full_unused;
  logic          w_instr_empty;
  logic [CW-1:0] w_instr_count;

  // Credits cover both words in flight and words buffered, so the buffer can never overflow.
  // Outstanding requests are exactly the occupancy of the tag FIFO.
  assign w_inflight     = {1'b0, w_outstanding} + {1'b0, w_instr_count};
  assign imem_req_valid = (w_inflight < DEPTH_LIM) && !w_halted;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Requests carry the epoch current at issue; a redirect in the same cycle leaves them stale
  assign w_tag_in   = '{pc: r_pc, epoch: r_epoch};
  assign w_rsp_pop  = imem_rsp_valid && !w_tag_empty;
  assign w_rsp_keep = w_rsp_pop && (w_tag_head.epoch == r_epoch) && !redirect_valid;
  assign w_entry_in = '{instr: imem_rsp_data, pc: w_tag_head.pc};

  assign instr_valid = !w_instr_empty;
  assign instr       = w_entry_head.instr;
  assign instr_pc    = w_entry_head.pc;

  sync_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (1'b0),
    .i_push    (w_req_fire),
    .i_wr_data (w_tag_in),
    .i_pop     (w_rsp_pop),
    .o_rd_data (w_tag_head),
    .o_full    (w_tag_full_unused),
    .o_empty   (w_tag_empty),
    .o_count   (w_outstanding)
  );

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (redirect_valid),
    .i_push    (w_rsp_keep),
    .i_wr_data (w_entry_in),
    .i_pop     (instr_ready),
    .o_rd_data (w_entry_head),
    .o_full    (w_instr_full_unused),
    .o_empty   (w_instr_empty),
    .o_count   (w_instr_count)
  );

  // PC and epoch: a redirect takes priority over the sequential advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_epoch <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= w_redirect_target;
      r_epoch <= ~r_epoch;
    end else if (w_req_fire) begin
      r_pc    <= next_pc(r_pc);
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        r_fault;
  logic [31:0] r_fault_pc;
  logic        w_misaligned;

  assign w_misaligned      = (redirect_pc[1:0] != 2'b00);
  assign w_redirect_target = redirect_pc;
  assign w_halted          = r_fault;
  assign fetch_fault       = r_fault;
  assign fault_pc          = r_fault_pc;

  // Sticky trap: every redirect re-evaluates it, so only an aligned redirect releases fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0;
    end else if (redirect_valid) begin
      r_fault    <= w_misaligned;
      r_fault_pc <= w_misaligned ? redirect_pc : 32'h0;
    end
  end
`else
  logic w_unused_redirect_lo;

  assign w_unused_redirect_lo = ^redirect_pc[1:0];
  assign w_redirect_target    = {redirect_pc[31:2], 2'b00};
  assign w_halted             = 1'b0;
  assign fetch_fault          = 1'b0;
  assign fault_pc             = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a stream-level reference model
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    int          lat;
    int          inflight;
    logic [31:0] target;
    logic [31:0] exp_pc;
  } redir_vec_t;

  mreq_t       memq[$];
  redir_vec_t  tbl[$];
  int          cyc, lat, checks, errors, req_count, consumed, max_out;
  bit          rand_ready, dec_rand, dec_val, redir_pend;
  logic [31:0] redir_tgt, exp_pc, exp_req, last_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  function automatic logic [31:0] redirect_model(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic tick();
    mreq_t m;
    @(negedge clk);
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(m.addr);
    end
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_req);
      exp_req += 32'd4;
      memq.push_back('{imem_req_addr, cyc + lat});
      req_count++;
    end
    if (memq.size() > max_out) max_out = memq.size();
    instr_ready    = dec_rand ? 1'($urandom_range(0, 1)) : dec_val;
    redirect_valid = redir_pend;
    redirect_pc    = redir_tgt;
    redir_pend     = 1'b0;
    if (instr_valid && instr_ready) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_word", instr, word_of(exp_pc));
      last_pc = instr_pc;
      exp_pc += 32'd4;
      consumed++;
    end
    if (redirect_valid) begin
      exp_pc  = redirect_model(redirect_pc);
      exp_req = exp_pc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    redir_pend     = 1'b0;
    memq.delete();
    #1;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_fetch_fault", fetch_fault, 0);
    chk("rst_fault_pc", fault_pc, 0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc     = 0;
    exp_pc  = RST_PC;
    exp_req = RST_PC;
    max_out = 0;
  endtask

  task automatic wait_consumed(input int target, input int budget, input string name);
    int n = 0;
    while (consumed < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(consumed >= target), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, streak, n;
    logic [31:0] tmp;
    checks = 0; errors = 0; req_count = 0; consumed = 0; cyc = 0; max_out = 0;
    lat = 1; rand_ready = 0; dec_rand = 0; dec_val = 1; redir_pend = 0;
    redir_tgt = 0; exp_pc = RST_PC; exp_req = RST_PC; last_pc = 0;

    tbl.push_back('{3, 2, 32'h0000_0100, 32'h0000_0100});
    tbl.push_back('{1, 1, 32'h0000_0040, 32'h0000_0040});
    tbl.push_back('{2, 3, 32'hFFFF_FFF8, 32'hFFFF_FFF8});
`ifndef FETCH_MISALIGN_TRAP_EN
    tbl.push_back('{1, 1, 32'h0000_0103, 32'h0000_0100});
`endif

    // Reset release, 1-cycle memory, decode always ready
    do_reset();
    tick();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, RST_PC);
    tick();
    chk("no_bypass", instr_valid, 0);
    tick();
    chk("first_instr_valid", instr_valid, 1);
    chk("first_instr_pc", instr_pc, RST_PC);
    streak = 0;
    repeat (8) begin
      tick();
      if (instr_valid) streak++;
    end
    chk("throughput", streak, 8);

    // Decode stalled: only FIFO_DEPTH requests may be accepted
    do_reset();
    dec_val = 0;
    base = req_count;
    repeat (10) tick();
    chk("stall_req_count", req_count - base, DEPTH);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_instr_valid", instr_valid, 1);
    dec_val = 1;
    wait_consumed(consumed + 12, 100, "stall_drain");

    // Redirect vectors with requests in flight
    for (int i = 0; i < tbl.size(); i++) begin
      do_reset();
      lat = tbl[i].lat;
      n = 0;
      while (memq.size() < tbl[i].inflight && n < 50) begin
        tick();
        n++;
      end
      redir_pend = 1;
      redir_tgt  = tbl[i].target;
      tick();
      base = consumed;
      wait_consumed(base + 1, 60, "tbl_wait");
      chk("tbl_next_pc", last_pc, tbl[i].exp_pc);
      wait_consumed(consumed + 3, 60, "tbl_follow");
    end
`ifndef FETCH_MISALIGN_TRAP_EN
    chk("default_fault_tied", fetch_fault, 0);
    chk("default_fault_pc_tied", fault_pc, 0);
`endif

    // Redirect coinciding with a request handshake and a response
    do_reset();
    lat = 1;
    repeat (6) tick();
    redir_pend = 1;
    redir_tgt  = 32'h0000_0400;
    tick();
    chk("same_cycle_req_fire", imem_req_valid & imem_req_ready, 1);
    chk("same_cycle_rsp", imem_rsp_valid, 1);
    tick();
    chk("after_redir_flushed", instr_valid, 0);
    chk("after_redir_addr", imem_req_addr, 32'h0000_0400);
    base = consumed;
    wait_consumed(base + 1, 20, "same_cycle_wait");
    chk("same_cycle_next_pc", last_pc, 32'h0000_0400);

    // Random memory and decode backpressure with occasional redirects
    do_reset();
    lat = 2; rand_ready = 1; dec_rand = 1;
    base = consumed;
    n = 0;
    while (consumed - base < 1000 && n < 20000) begin
      if ($urandom_range(0, 59) == 0) begin
        tmp = $urandom();
        tmp[1:0] = 2'b00;
        redir_pend = 1;
        redir_tgt  = tmp;
      end
      tick();
      n++;
    end
    chk("random_count", 32'(consumed - base >= 1000), 1);
    chk("max_outstanding_ok", 32'(max_out <= DEPTH), 1);
    rand_ready = 0; dec_rand = 0; dec_val = 1;

    // Reset asserted mid-operation, then fetch restarts from the reset PC
    lat = 3;
    repeat (4) tick();
    do_reset();
    base = consumed;
    wait_consumed(base + 4, 40, "post_reset_run");

`ifdef FETCH_MISALIGN_TRAP_EN
    do_reset();
    lat = 1;
    repeat (5) tick();
    redir_pend = 1;
    redir_tgt  = 32'h0000_0102;
    tick();
    tick();
    chk("trap_fault", fetch_fault, 1);
    chk("trap_fault_pc", fault_pc, 32'h0000_0102);
    chk("trap_req_valid", imem_req_valid, 0);
    base = req_count;
    repeat (6) tick();
    chk("trap_no_req", req_count - base, 0);
    redir_pend = 1;
    redir_tgt  = 32'h0000_0200;
    tick();
    tick();
    chk("trap_cleared", fetch_fault, 0);
    chk("trap_resume_addr", imem_req_addr, 32'h0000_0200);
    base = consumed;
    wait_consumed(base + 1, 30, "trap_resume_wait");
    chk("trap_resume_pc", last_pc, 32'h0000_0200);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction decoder. Owns the PC, issues in-order word reads to instruction memory over a valid/ready request channel, buffers returned words with their PC, and presents them to decode via a valid/ready handshake. Branch and JAL redirects from execute flush buffered and in-flight fetches using an epoch bit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding requests (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  read data valid, in request order, one per accepted request
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  instr/instr_pc valid to decode
- instr_ready  in  1  decode consumes word
- instr  out  32  instruction word to decode
- instr_pc  out  32  PC of instr
- redirect_valid  in  1  taken branch/JAL, one-cycle pulse
- redirect_pc  in  32  redirect target
- fetch_fault  out  1  misaligned redirect (only with FETCH_MISALIGN_TRAP_EN; tied 0 otherwise)
- fault_pc  out  32  faulting target (tied 0 without the macro)

## Operation
- Credits: imem_req_valid = (outstanding + fifo_count < FIFO_DEPTH) and not halted. Purely combinational from registered state; never depends on redirect_valid.
- On request handshake (valid & ready): push {pc, epoch} into tag FIFO, outstanding++, pc <= pc + 4 (wraps at 2^32).
- On imem_rsp_valid: pop tag FIFO, outstanding--. If tag epoch == current epoch, push {data, tag pc} into instruction FIFO; else discard.
- Same-cycle request and response: outstanding unchanged.
- Redirect: epoch toggles, instruction FIFO flushed, pc <= redirect_pc. Redirect wins over a same-cycle pc+4 advance. A request handshaking in the redirect cycle is tagged with the old epoch and its response is discarded. Responses still in flight keep the old epoch and are discarded; outstanding counts them until returned.
- Response arriving in the redirect cycle is discarded regardless of tag.
- Decode pop on instr_valid & instr_ready; a pop and push in the same cycle are allowed at any occupancy.
- Credit rule guarantees no instruction FIFO overflow; a response with outstanding == 0 is a protocol error (bench assertion).

## Timing
- Reset values: pc = RESET_PC, epoch = 0, outstanding = 0, both FIFOs empty, instr_valid = 0, instr = 0, instr_pc = 0, fetch_fault = 0, fault_pc = 0.
- imem_req_valid = 1 with imem_req_addr = RESET_PC in the first cycle after rst_n deasserts.
- Response in cycle N → instr_valid in cycle N+1 (registered buffer, no bypass).
- Redirect in cycle N → instr_valid = 0 in N+1; new request at redirect_pc issued from N+1.
- Back-to-back throughput: one instruction per cycle with 1-cycle memory latency and instr_ready held high.
- rst_n asserted mid-operation: all state returns to reset values immediately; later memory responses are the environment's responsibility to squash.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0] != 0 sets sticky fetch_fault, captures fault_pc, flushes as a normal redirect, and halts requests (imem_req_valid = 0). A later aligned redirect clears fetch_fault and resumes fetch.
- Not defined: redirect_pc[1:0] forced to 2'b00; fetch_fault and fault_pc tied 0.

## Structure
- Package fetch_pkg: fetch_tag_t {pc[31:0], epoch}, fetch_entry_t {instr[31:0], pc[31:0]}, INSTR_NOP = 32'h0000_0013, PC_INCR = 4.
- Sub-module sync_fifo (parameterised width/depth, flush input, full/empty/count), instanced twice: tag FIFO and instruction FIFO.

## Test plan
- Reset release, 1-cycle memory, instr_ready = 1 → requests 0x0, 0x4, 0x8…; instr_pc 0x0 appears two cycles after reset release, then one word per cycle.
- instr_ready = 0 for 10 cycles → exactly FIFO_DEPTH requests accepted, imem_req_valid = 0 thereafter; releasing ready delivers words in order, none lost.
- 3-cycle memory latency, redirect to 0x100 with 2 requests in flight → both stale responses dropped, next instr_pc = 0x100.
- Redirect in same cycle as request handshake and response → neither reaches decode; pc = target next cycle.
- imem_req_ready random 50%, 1000 instructions → instr_pc strictly pc+4 sequence except at redirects; outstanding never exceeds FIFO_DEPTH.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 → fetch_fault = 1, fault_pc = 0x102, no requests; redirect to 0x200 → fault clears, fetch resumes at 0x200.
